// File: rtl/out_display.sv
// Output-register byte -> 4-digit multiplexed 7-segment display via sequential double-dabble.
// New value appears 9 CLK edges after it is accepted; inputs arriving while BUSY are picked up afterwards.
module out_display #(
  parameter int SCAN_DIV       = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] OBUS,
  input  logic       SIGNED,
  output logic [6:0] SEG,
  output logic [3:0] DIG,
  output logic       BUSY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int PW = $clog2(SCAN_DIV);

  logic [1:0]    r_state;
  logic [8:0]    r_last;
  logic [7:0]    r_mag;
  logic [11:0]   r_bcd;
  logic [2:0]    r_step;
  logic          r_neg_c;
  logic [3:0]    r_d0, r_d1, r_d2;
  logic          r_neg, r_blank_h, r_blank_t;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;

  logic [8:0]    w_in;
  logic [7:0]    w_mag_in;
  logic [11:0]   w_adj;
  logic [6:0]    w_seg;

  assign w_in     = {SIGNED, OBUS};
  assign w_mag_in = (SIGNED & OBUS[7]) ? (~OBUS + 8'd1) : OBUS;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state   <= S_IDLE;
      r_last    <= 9'd0;
      r_mag     <= 8'd0;
      r_bcd     <= 12'd0;
      r_step    <= 3'd0;
      r_neg_c   <= 1'b0;
      r_d0      <= 4'd0;
      r_d1      <= 4'd0;
      r_d2      <= 4'd0;
      r_neg     <= 1'b0;
      r_blank_h <= 1'b1;
      r_blank_t <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in != r_last) begin
            r_last  <= w_in;
            r_mag   <= w_mag_in;
            r_neg_c <= SIGNED & OBUS[7];
            r_bcd   <= 12'd0;
            r_step  <= 3'd0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          // Adjust-then-shift on the concatenated {BCD, magnitude} register.
          r_bcd  <= {w_adj[10:0], r_mag[7]};
          r_mag  <= {r_mag[6:0], 1'b0};
          r_step <= r_step + 3'd1;
          if (r_step == 3'd7)
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_d0      <= r_bcd[3:0];
          r_d1      <= r_bcd[7:4];
          r_d2      <= r_bcd[11:8];
          r_neg     <= r_neg_c;
          r_blank_h <= (r_bcd[11:8] == 4'd0);
          r_blank_t <= (r_bcd[11:4] == 8'd0);
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_pre <= '0;
      r_idx <= 2'd0;
    end else if (r_pre == PW'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    case (d)
      4'd0:    f_glyph = 7'h3F;
      4'd1:    f_glyph = 7'h06;
      4'd2:    f_glyph = 7'h5B;
      4'd3:    f_glyph = 7'h4F;
      4'd4:    f_glyph = 7'h66;
      4'd5:    f_glyph = 7'h6D;
      4'd6:    f_glyph = 7'h7D;
      4'd7:    f_glyph = 7'h07;
      4'd8:    f_glyph = 7'h7F;
      4'd9:    f_glyph = 7'h6F;
      default: f_glyph = 7'h00;
    endcase
  endfunction

  // Outputs depend only on registers, so they settle once per CLK edge.
  always_comb begin
    w_seg = 7'h00;
    case (r_idx)
      2'd0: w_seg = f_glyph(r_d0);
      2'd1: w_seg = r_blank_t ? 7'h00 : f_glyph(r_d1);
      2'd2: w_seg = r_blank_h ? 7'h00 : f_glyph(r_d2);
      2'd3: w_seg = r_neg ? 7'h40 : 7'h00;
      default: w_seg = 7'h00;
    endcase
  end

  assign SEG  = SEG_ACTIVE_LOW ? ~w_seg : w_seg;
  assign DIG  = 4'b0001 << r_idx;
  assign BUSY = (r_state != S_IDLE);

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display: two instances (active-high and active-low SEG) share all inputs.
module tb_out_display;

  localparam int SCAN = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] obus;
  logic       sgn;
  logic [6:0] seg, seg_al;
  logic [3:0] dig, dig_al;
  logic       busy, busy_al;

  int checks = 0;
  int errors = 0;

  logic [6:0] cap_a [4];
  logic [6:0] cap_b [4];

  always #5 clk = ~clk;

  out_display #(.SCAN_DIV(SCAN), .SEG_ACTIVE_LOW(1'b0)) u_dut (
    .CLK(clk), .CLR(clr), .OBUS(obus), .SIGNED(sgn),
    .SEG(seg), .DIG(dig), .BUSY(busy)
  );

  out_display #(.SCAN_DIV(SCAN), .SEG_ACTIVE_LOW(1'b1)) u_dut_al (
    .CLK(clk), .CLR(clr), .OBUS(obus), .SIGNED(sgn),
    .SEG(seg_al), .DIG(dig_al), .BUSY(busy_al)
  );

  function automatic logic [2:0] dig_idx(input logic [3:0] d);
    case (d)
      4'b0001: dig_idx = 3'd0;
      4'b0010: dig_idx = 3'd1;
      4'b0100: dig_idx = 3'd2;
      4'b1000: dig_idx = 3'd3;
      default: dig_idx = 3'd4;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    bit done;
    done = 1'b0;
    n = 999;
    for (int k = 1; k <= 40; k++) begin
      if (!done) begin
        tick();
        if (busy === 1'b0) begin
          n = k;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic capture_scan;
    for (int i = 0; i < 4; i++) begin
      cap_a[i] = 7'bx;
      cap_b[i] = 7'bx;
    end
    for (int k = 0; k < 4 * SCAN; k++) begin
      tick();
      if (dig_idx(dig) < 3'd4) begin
        cap_a[dig_idx(dig)] = seg;
        cap_b[dig_idx(dig)] = seg_al;
      end
    end
  endtask

  // Drive a value, wait for the conversion to finish, then record one full scan.
  task automatic convert(input logic [7:0] v, input logic s, output int n);
    obus = v;
    sgn  = s;
    tick();
    wait_idle(n);
    capture_scan();
  endtask

  task automatic test_reset;
    logic [6:0] want [4];
    want = '{7'h3F, 7'h00, 7'h00, 7'h00};
    clr = 1'b1; obus = 8'h00; sgn = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (dig !== 4'b0001) begin errors++; $display("FAIL reset_dig got %b want 0001", dig); end
    checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL reset_seg got %h want 3f", seg); end
    checks++; if (seg_al !== 7'h40) begin errors++; $display("FAIL reset_seg_al got %h want 40", seg_al); end
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_noconv busy=%b want 0", busy); end
    end
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_a[i] !== want[i]) begin errors++; $display("FAIL reset_d%0d got %h want %h", i, cap_a[i], want[i]); end
    end
  endtask

  task automatic test_unsigned;
    logic [6:0] old_v [4];
    logic [6:0] want [4];
    logic [2:0] di;
    old_v = '{7'h3F, 7'h00, 7'h00, 7'h00};
    want  = '{7'h4F, 7'h5B, 7'h06, 7'h00};
    obus = 8'h7B; sgn = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL u123_busy_rise got %b want 1", busy); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      di = dig_idx(dig);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL u123_busy_n%0d got %b want 1", k, busy); end
      checks++; if (di[2] || seg !== old_v[di[1:0]]) begin errors++; $display("FAIL u123_hold_n%0d dig=%b seg=%h", k, dig, seg); end
    end
    tick();
    di = dig_idx(dig);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL u123_busy_fall got %b want 0", busy); end
    checks++; if (di[2] || seg !== want[di[1:0]]) begin errors++; $display("FAIL u123_n9 dig=%b seg=%h", dig, seg); end
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_a[i] !== want[i]) begin errors++; $display("FAIL u123_d%0d got %h want %h", i, cap_a[i], want[i]); end
      checks++; if (cap_b[i] !== ~want[i]) begin errors++; $display("FAIL u123_al_d%0d got %h want %h", i, cap_b[i], ~want[i]); end
    end
  endtask

  task automatic test_signed;
    logic [6:0] want [4];
    int n;
    want = '{7'h06, 7'h00, 7'h00, 7'h40};
    convert(8'hFF, 1'b1, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL sgn_m1_lat got %0d want 9", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_a[i] !== want[i]) begin errors++; $display("FAIL sgn_m1_d%0d got %h want %h", i, cap_a[i], want[i]); end
      checks++; if (cap_b[i] !== ~want[i]) begin errors++; $display("FAIL sgn_m1_al_d%0d got %h want %h", i, cap_b[i], ~want[i]); end
    end
    want = '{7'h7F, 7'h5B, 7'h06, 7'h40};
    convert(8'h80, 1'b1, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL sgn_m128_lat got %0d want 9", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_a[i] !== want[i]) begin errors++; $display("FAIL sgn_m128_d%0d got %h want %h", i, cap_a[i], want[i]); end
    end
  endtask

  task automatic test_zeros;
    logic [6:0] want [4];
    int n;
    want = '{7'h3F, 7'h3F, 7'h06, 7'h00};
    convert(8'h64, 1'b0, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL z100_lat got %0d want 9", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_a[i] !== want[i]) begin errors++; $display("FAIL z100_d%0d got %h want %h", i, cap_a[i], want[i]); end
    end
    want = '{7'h3F, 7'h06, 7'h00, 7'h00};
    convert(8'h0A, 1'b0, n);
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_a[i] !== want[i]) begin errors++; $display("FAIL z10_d%0d got %h want %h", i, cap_a[i], want[i]); end
      checks++; if (cap_b[i] !== ~want[i]) begin errors++; $display("FAIL z10_al_d%0d got %h want %h", i, cap_b[i], ~want[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] want5 [4];
    logic [6:0] want9 [4];
    logic [2:0] di;
    int n;
    want5 = '{7'h6D, 7'h00, 7'h00, 7'h00};
    want9 = '{7'h6F, 7'h00, 7'h00, 7'h00};
    obus = 8'h05; sgn = 1'b0;
    tick();
    tick(); tick();
    obus = 8'h09;
    wait_idle(n);
    di = dig_idx(dig);
    checks++; if (n !== 7) begin errors++; $display("FAIL b2b_first_end got %0d want 7", n); end
    checks++; if (di[2] || seg !== want5[di[1:0]]) begin errors++; $display("FAIL b2b_shows5 dig=%b seg=%h", dig, seg); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_retrigger got %b want 1", busy); end
    wait_idle(n);
    checks++; if (n !== 9) begin errors++; $display("FAIL b2b_second_lat got %0d want 9", n); end
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_a[i] !== want9[i]) begin errors++; $display("FAIL b2b_d%0d got %h want %h", i, cap_a[i], want9[i]); end
    end
  endtask

  task automatic test_scan;
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    clr = 1'b1; obus = 8'h00; sgn = 1'b0;
    tick();
    clr = 1'b0;
    checks++; if (dig !== 4'b0001) begin errors++; $display("FAIL scan_start got %b want 0001", dig); end
    for (int t = 0; t < 4; t++) begin
      tick(); tick(); tick();
      checks++; if (dig !== seq[t]) begin errors++; $display("FAIL scan_hold%0d got %b want %b", t, dig, seq[t]); end
      tick();
      checks++; if (dig !== seq[t+1]) begin errors++; $display("FAIL scan_step%0d got %b want %b", t, dig, seq[t+1]); end
    end
  endtask

  task automatic test_clr_mid;
    logic [6:0] want [4];
    int n;
    want = '{7'h4F, 7'h5B, 7'h06, 7'h00};
    obus = 8'h7B; sgn = 1'b0;
    tick();
    tick(); tick(); tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_pre_busy got %b want 1", busy); end
    clr = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
    checks++; if (dig !== 4'b0001) begin errors++; $display("FAIL clr_dig got %b want 0001", dig); end
    checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL clr_seg got %h want 3f", seg); end
    tick();
    clr = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_retrigger got %b want 1", busy); end
    wait_idle(n);
    checks++; if (n !== 9) begin errors++; $display("FAIL clr_conv_lat got %0d want 9", n); end
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_a[i] !== want[i]) begin errors++; $display("FAIL clr_d%0d got %h want %h", i, cap_a[i], want[i]); end
    end
  endtask

  initial begin
    clr = 1'b1;
    obus = 8'h00;
    sgn = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_zeros();
    test_back_to_back();
    test_scan();
    test_clr_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
